flag_forward_unit: RTL

Producer side of the condition-flag path into the ID-stage branch verifier. It holds the architectural carry and zero flags and tracks flag writes in flight through EX, MEM and WB. It presents the correct C/Z for the branch in ID, either forwarded or stalled. The flag pair it drives is exactly the Cin/Zin consumed by the branch-verify logic. Flags are written when an instruction reaches WB.

---
 rtl/flag_forward_unit_if.sv | 60 ++++++
 rtl/flag_forward_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/flag_forward_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : flag_forward_unit_if
// Brief    : Pipeline-side bundle for the condition-flag forwarding unit.
//            The master drives the ID opcode, EX flag results and the
//            pipeline freeze; the slave (flag_forward_unit) returns the
//            branch flags, the stall request and the architectural flags.
// Revision : 1.0 - initial release
// ============================================================================
interface flag_forward_unit_if #(
  parameter int OPW = 5
);

  logic [OPW-1:0] id_opcode;
  logic           ex_valid;
  logic           ex_cwe;
  logic           ex_zwe;
  logic           ex_c;
  logic           ex_z;
  logic           pipe_hold;
  logic           Cout;
  logic           Zout;
  logic           flag_stall;
  logic           c_reg;
  logic           z_reg;

  // Pipeline / stimulus side.
  modport master (
    output id_opcode,
    output ex_valid,
    output ex_cwe,
    output ex_zwe,
    output ex_c,
    output ex_z,
    output pipe_hold,
    input  Cout,
    input  Zout,
    input  flag_stall,
    input  c_reg,
    input  z_reg
  );

  // Flag unit side.
  modport slave (
    input  id_opcode,
    input  ex_valid,
    input  ex_cwe,
    input  ex_zwe,
    input  ex_c,
    input  ex_z,
    input  pipe_hold,
    output Cout,
    output Zout,
    output flag_stall,
    output c_reg,
    output z_reg
  );

endinterface
`default_nettype wire

// File: rtl/flag_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_forward_unit
// Brief    : Holds the architectural C/Z flags, tracks flag writes in flight
//            through EX, MEM and WB, and presents the correct C/Z to the
//            ID-stage branch verifier.
//            Build option FLAG_FWD_EN:
//              defined   - flags are forwarded from EX/MEM/WB, never stalls.
//              undefined - flags come only from the architectural registers
//                          and a hazard comparator raises flag_stall.
// Revision : 1.0 - initial release
// ============================================================================
module flag_forward_unit #(
  parameter int OPW = 5
) (
  input wire               clk,
  input wire               rst,   // asynchronous, active-low
  flag_forward_unit_if.slave bus
);

  // Branch opcodes that consume a flag.
  localparam logic [OPW-1:0] c_OP_BR_Z0 = OPW'(5'b10100);
  localparam logic [OPW-1:0] c_OP_BR_Z1 = OPW'(5'b10101);
  localparam logic [OPW-1:0] c_OP_BR_C0 = OPW'(5'b10110);
  localparam logic [OPW-1:0] c_OP_BR_C1 = OPW'(5'b10111);

  // One in-flight flag writer.
  typedef struct packed {
    logic valid;
    logic cwe;
    logic zwe;
    logic c;
    logic z;
  } slot_t;

  slot_t r_memSlot;
  slot_t r_wbSlot;
  slot_t w_exSlot;
  logic  r_cFlag;
  logic  r_zFlag;

  logic  w_needC;
  logic  w_needZ;
  logic  w_exCw;
  logic  w_exZw;
  logic  w_memCw;
  logic  w_memZw;
  logic  w_wbCw;
  logic  w_wbZw;
  logic  w_cSel;
  logic  w_zSel;
  logic  w_stall;

  // Write enables only count for real instructions; bubbles carry nothing.
  always_comb begin
    w_exSlot       = '0;
    w_exSlot.valid = bus.ex_valid;
    w_exSlot.cwe   = bus.ex_valid & bus.ex_cwe;
    w_exSlot.zwe   = bus.ex_valid & bus.ex_zwe;
    w_exSlot.c     = bus.ex_c;
    w_exSlot.z     = bus.ex_z;
  end

  // Advance the MEM/WB tracking slots unless the pipeline is frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memSlot <= '0;
      r_wbSlot  <= '0;
    end else if (!bus.pipe_hold) begin
      r_memSlot <= w_exSlot;
      r_wbSlot  <= r_memSlot;
    end
  end

  // Commit the WB writer into the architectural flags, each flag on its own enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cFlag <= 1'b0;
      r_zFlag <= 1'b0;
    end else if (!bus.pipe_hold && r_wbSlot.valid) begin
      if (r_wbSlot.cwe) begin
        r_cFlag <= r_wbSlot.c;
      end
      if (r_wbSlot.zwe) begin
        r_zFlag <= r_wbSlot.z;
      end
    end
  end

  // Decode which flag the branch in ID depends on.
  always_comb begin
    w_needC = 1'b0;
    w_needZ = 1'b0;
    if ((bus.id_opcode == c_OP_BR_Z0) || (bus.id_opcode == c_OP_BR_Z1)) begin
      w_needZ = 1'b1;
    end
    if ((bus.id_opcode == c_OP_BR_C0) || (bus.id_opcode == c_OP_BR_C1)) begin
      w_needC = 1'b1;
    end
  end

  // Per-stage pending writes for each flag, qualified by slot validity.
  always_comb begin
    w_exCw  = w_exSlot.cwe;
    w_exZw  = w_exSlot.zwe;
    w_memCw = r_memSlot.valid & r_memSlot.cwe;
    w_memZw = r_memSlot.valid & r_memSlot.zwe;
    w_wbCw  = r_wbSlot.valid & r_wbSlot.cwe;
    w_wbZw  = r_wbSlot.valid & r_wbSlot.zwe;
  end

`ifdef FLAG_FWD_EN
  // Youngest writer wins: EX, then MEM, then WB, then the architectural flag.
  always_comb begin
    w_cSel  = r_cFlag;
    w_zSel  = r_zFlag;
    w_stall = 1'b0;
    if (w_exCw) begin
      w_cSel = w_exSlot.c;
    end else if (w_memCw) begin
      w_cSel = r_memSlot.c;
    end else if (w_wbCw) begin
      w_cSel = r_wbSlot.c;
    end
    if (w_exZw) begin
      w_zSel = w_exSlot.z;
    end else if (w_memZw) begin
      w_zSel = r_memSlot.z;
    end else if (w_wbZw) begin
      w_zSel = r_wbSlot.z;
    end
  end
`else
  // No bypass: present the architectural flags and stall while a needed flag is in flight.
  always_comb begin
    w_cSel  = r_cFlag;
    w_zSel  = r_zFlag;
    w_stall = (w_needC & (w_exCw | w_memCw | w_wbCw)) |
              (w_needZ & (w_exZw | w_memZw | w_wbZw));
  end
`endif

  // Outputs read zero while reset is asserted, regardless of what EX presents.
  always_comb begin
    bus.Cout       = rst & w_cSel;
    bus.Zout       = rst & w_zSel;
    bus.flag_stall = rst & w_stall;
    bus.c_reg      = r_cFlag;
    bus.z_reg      = r_zFlag;
  end

endmodule
`default_nettype wire
